myfilter_ctrl: RTL and testbench

Sequencing controller for the single-multiplier FIR datapath in the myfilter design. It accepts input samples over a valid/ready handshake and writes them into the delay-line RAM. It then steps one shared MAC across all taps, waits out the MAC pipeline latency, and presents the result over a valid/ready handshake. It also zero-fills the delay line after reset and on request. It is placed between the input stream and the delay-line, coefficient-ROM and MAC datapath, and runs in the synchronized-reset domain.

---
 rtl/myfilter_ctrl_if.sv | 11 +
 rtl/myfilter_ctrl.sv | 141 ++++++++++++++
 tb/tb_myfilter_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/myfilter_ctrl_if.sv
// Sample-in and result-out valid/ready handshakes of the FIR sequencing controller.
// The controller side uses the slave modport; the stream source/sink uses master.
interface myfilter_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (output in_valid, output out_ready, input in_ready, input out_valid);
  modport slave  (input in_valid, input out_ready, output in_ready, output out_valid);
endinterface

// File: rtl/myfilter_ctrl.sv
// Sequencer for the single-MAC FIR datapath: sample write, tap stepping, MAC latency wait,
// result handshake, and zero-fill of the delay line after reset or on request.
//
// state | meaning
// RST_S | reset, all outputs 0
// FLUSH | zero-fill delay line, one address per cycle
// IDLE  | ready for a sample or a flush request
// MAC   | one tap per cycle through the shared MAC
// WAIT  | drain MAC pipeline latency
// OUT   | result valid, held until accepted
module myfilter_ctrl #(
  parameter int TAPS    = 8,
  parameter int MAC_LAT = 2,
  parameter int ADDR_W  = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              srst,
  myfilter_ctrl_if.slave    hs,
  input  logic              flush_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              zero_sel,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic              mac_en,
  output logic              mac_clear,
  output logic              busy
);

  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [ADDR_W-1:0] TAP_LAST = ADDR_W'(TAPS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
  localparam logic [ADDR_W:0]   TAPS_X   = (ADDR_W + 1)'(TAPS);

  typedef enum logic [2:0] {RST_S, FLUSH, IDLE, MAC, WAIT, OUT} state_t;

  state_t            state, nxt_state;
  logic [ADDR_W-1:0] tap_cnt, nxt_tap;
  logic [ADDR_W-1:0] wr_ptr, nxt_ptr;
  logic [LAT_W-1:0]  lat_cnt, nxt_lat;
  logic [ADDR_W:0]   rd_sum;
  logic [ADDR_W-1:0] rd_next;
  logic              out_valid_q;

  assign hs.in_ready  = (state == IDLE) && !flush_req;
  assign hs.out_valid = out_valid_q;
  assign wr_en        = zero_sel | (hs.in_ready & hs.in_valid);

  always_comb begin
    nxt_state = state;
    nxt_tap   = tap_cnt;
    nxt_lat   = lat_cnt;
    nxt_ptr   = wr_ptr;
    case (state)
      RST_S: begin
        nxt_state = FLUSH;
        nxt_tap   = '0;
      end
      FLUSH: begin
        if (tap_cnt == TAP_LAST) begin
          nxt_tap   = '0;
          nxt_state = IDLE;
        end else begin
          nxt_tap = tap_cnt + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (flush_req) begin
          nxt_ptr   = '0;
          nxt_tap   = '0;
          nxt_state = FLUSH;
        end else if (hs.in_valid) begin
          nxt_tap   = '0;
          nxt_state = MAC;
        end
      end
      MAC: begin
        if (tap_cnt == TAP_LAST) begin
          nxt_tap   = '0;
          nxt_state = (MAC_LAT > 0) ? WAIT : OUT;
        end else begin
          nxt_tap = tap_cnt + ADDR_W'(1);
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          nxt_lat   = '0;
          nxt_state = OUT;
        end else begin
          nxt_lat = lat_cnt + LAT_W'(1);
        end
      end
      OUT: begin
        if (hs.out_ready) begin
          nxt_ptr   = (wr_ptr == TAP_LAST) ? '0 : wr_ptr + ADDR_W'(1);
          nxt_state = IDLE;
        end
      end
      default: nxt_state = RST_S;
    endcase
  end

  // Newest sample minus tap index, wrapped mod TAPS in one extra bit so non-power-of-two TAPS works.
  always_comb begin
    rd_sum  = {1'b0, nxt_ptr} + TAPS_X - {1'b0, nxt_tap};
    rd_next = ADDR_W'((rd_sum >= TAPS_X) ? rd_sum - TAPS_X : rd_sum);
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= RST_S;
      tap_cnt     <= '0;
      lat_cnt     <= '0;
      wr_ptr      <= '0;
      zero_sel    <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      coeff_addr  <= '0;
      mac_en      <= 1'b0;
      mac_clear   <= 1'b0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= nxt_state;
      tap_cnt     <= nxt_tap;
      lat_cnt     <= nxt_lat;
      wr_ptr      <= nxt_ptr;
      zero_sel    <= (nxt_state == FLUSH);
      wr_addr     <= (nxt_state == FLUSH) ? nxt_tap :
                     (nxt_state == IDLE)  ? nxt_ptr : '0;
      rd_addr     <= (nxt_state == MAC) ? rd_next : '0;
      coeff_addr  <= (nxt_state == MAC) ? nxt_tap : '0;
      mac_en      <= (nxt_state == MAC);
      mac_clear   <= (nxt_state == MAC) && (nxt_tap == '0);
      out_valid_q <= (nxt_state == OUT);
      busy        <= (nxt_state != IDLE);
    end
  end

endmodule

// File: tb/tb_myfilter_ctrl.sv
// Bench for myfilter_ctrl: a TAPS=4/MAC_LAT=2 instance with a delay-line/MAC datapath model
// checked against a reference FIR, plus a TAPS=5/MAC_LAT=0 instance for latency and wrap.
module tb_myfilter_ctrl;
  localparam int T0 = 4;
  localparam int L0 = 2;
  localparam int T1 = 5;
  localparam int L1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       srst0, flush0, wr_en0, zero0, mac_en0, mac_clr0, busy0;
  logic [1:0] wr_addr0, rd0, coeff0;
  myfilter_ctrl_if hs0 ();
  myfilter_ctrl #(.TAPS(T0), .MAC_LAT(L0)) dut0 (
    .clk(clk), .srst(srst0), .hs(hs0), .flush_req(flush0), .wr_en(wr_en0),
    .wr_addr(wr_addr0), .zero_sel(zero0), .rd_addr(rd0), .coeff_addr(coeff0),
    .mac_en(mac_en0), .mac_clear(mac_clr0), .busy(busy0));

  logic       srst1, flush1, wr_en1, zero1, mac_en1, mac_clr1, busy1;
  logic [2:0] wr_addr1, rd1, coeff1;
  myfilter_ctrl_if hs1 ();
  myfilter_ctrl #(.TAPS(T1), .MAC_LAT(L1)) dut1 (
    .clk(clk), .srst(srst1), .hs(hs1), .flush_req(flush1), .wr_en(wr_en1),
    .wr_addr(wr_addr1), .zero_sel(zero1), .rd_addr(rd1), .coeff_addr(coeff1),
    .mac_en(mac_en1), .mac_clear(mac_clr1), .busy(busy1));

  // Datapath model: delay-line RAM and MAC driven by the controller strobes.
  int din0 = 0;
  int ram0 [T0];
  int acc0 = 0;
  int coef0 [T0] = '{5, 3, 7, 2};
  always @(posedge clk) begin
    if (wr_en0 === 1'b1) ram0[wr_addr0] <= (zero0 === 1'b1) ? 0 : din0;
    if (mac_en0 === 1'b1) acc0 <= ((mac_clr0 === 1'b1) ? 0 : acc0) + coef0[coeff0] * ram0[rd0];
  end

  // Reference: last TAPS accepted samples since the latest flush, newest first.
  int hist0 [T0];
  int exp_ptr0 = 0;

  task automatic clear_model();
    for (int k = 0; k < T0; k++) hist0[k] = 0;
    exp_ptr0 = 0;
  endtask

  task automatic run_sample(input int x, input int hold, input bit noise);
    int exp_y;
    @(negedge clk);
    hs0.in_valid = 1'b1; flush0 = 1'b0; din0 = x; hs0.out_ready = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (hs0.in_ready !== 1'b1 || wr_en0 !== 1'b1 || zero0 !== 1'b0 || wr_addr0 !== 2'(exp_ptr0)) begin
      errors++;
      $display("FAIL accept: in_ready=%b wr_en=%b zero_sel=%b wr_addr=%0d, want 1 1 0 %0d",
               hs0.in_ready, wr_en0, zero0, wr_addr0, exp_ptr0);
    end
    for (int k = T0 - 1; k > 0; k--) hist0[k] = hist0[k-1];
    hist0[0] = x;
    exp_y = 0;
    for (int k = 0; k < T0; k++) exp_y += coef0[k] * hist0[k];
    for (int k = 0; k < T0; k++) begin
      @(negedge clk);
      hs0.in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      flush0 = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      hs0.out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (mac_en0 !== 1'b1 || coeff0 !== 2'(k) || rd0 !== 2'((exp_ptr0 - k + T0) % T0) ||
          mac_clr0 !== (k == 0) || wr_en0 !== 1'b0 || hs0.in_ready !== 1'b0 || hs0.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mac tap %0d: mac_en=%b coeff=%0d rd=%0d clear=%b wr_en=%b in_ready=%b out_valid=%b, want 1 %0d %0d %b 0 0 0",
                 k, mac_en0, coeff0, rd0, mac_clr0, wr_en0, hs0.in_ready, hs0.out_valid,
                 k, (exp_ptr0 - k + T0) % T0, k == 0);
      end
    end
    for (int k = 0; k < L0; k++) begin
      @(negedge clk);
      hs0.in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      flush0 = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      checks++;
      if (mac_en0 !== 1'b0 || hs0.out_valid !== 1'b0 || busy0 !== 1'b1 || wr_en0 !== 1'b0) begin
        errors++;
        $display("FAIL wait %0d: mac_en=%b out_valid=%b busy=%b wr_en=%b, want 0 0 1 0",
                 k, mac_en0, hs0.out_valid, busy0, wr_en0);
      end
    end
    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      hs0.out_ready = (k == hold);
      hs0.in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b1;
      flush0 = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      checks++;
      if (hs0.out_valid !== 1'b1 || hs0.in_ready !== 1'b0 || wr_en0 !== 1'b0 || acc0 !== exp_y) begin
        errors++;
        $display("FAIL out %0d/%0d: out_valid=%b in_ready=%b wr_en=%b result=%0d, want 1 0 0 %0d",
                 k, hold, hs0.out_valid, hs0.in_ready, wr_en0, acc0, exp_y);
      end
    end
    exp_ptr0 = (exp_ptr0 + 1) % T0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    hs0.in_valid = 1'b0; flush0 = 1'b0; hs0.out_ready = 1'b1;
    #1;
    checks++;
    if (hs0.in_ready !== 1'b1 || hs0.out_valid !== 1'b0 || busy0 !== 1'b0 || wr_en0 !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: in_ready=%b out_valid=%b busy=%b wr_en=%b, want 1 0 0 0",
               tag, hs0.in_ready, hs0.out_valid, busy0, wr_en0);
    end
  endtask

  task automatic check_reset_flush(input string tag);
    checks++;
    if ({wr_en0, zero0, mac_en0, mac_clr0, busy0, hs0.in_ready, hs0.out_valid} !== 7'b0 ||
        wr_addr0 !== 2'd0 || rd0 !== 2'd0 || coeff0 !== 2'd0) begin
      errors++;
      $display("FAIL %s rst_state: wr_en=%b zero=%b mac_en=%b clr=%b busy=%b in_ready=%b out_valid=%b, want all 0",
               tag, wr_en0, zero0, mac_en0, mac_clr0, busy0, hs0.in_ready, hs0.out_valid);
    end
    for (int i = 0; i < T0; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (wr_en0 !== 1'b1 || zero0 !== 1'b1 || wr_addr0 !== 2'(i) || busy0 !== 1'b1 ||
          hs0.in_ready !== 1'b0 || mac_en0 !== 1'b0 || hs0.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s flush %0d: wr_en=%b zero=%b wr_addr=%0d busy=%b in_ready=%b mac_en=%b out_valid=%b, want 1 1 %0d 1 0 0 0",
                 tag, i, wr_en0, zero0, wr_addr0, busy0, hs0.in_ready, mac_en0, hs0.out_valid, i);
      end
    end
    clear_model();
    check_idle(tag);
  endtask

  task automatic test_reset();
    @(negedge clk);
    srst0 = 1'b1; hs0.in_valid = 1'b0; hs0.out_ready = 1'b0; flush0 = 1'b0;
    @(negedge clk);
    srst0 = 1'b0;
    #1;
    check_reset_flush("reset");
  endtask

  task automatic test_single();
    run_sample(int'($urandom_range(0, 255)), 0, 1'b0);
    check_idle("single");
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 4; s++) run_sample(int'($urandom_range(0, 255)), 0, 1'b0);
    check_idle("back_to_back");
  endtask

  task automatic test_backpressure();
    run_sample(int'($urandom_range(0, 255)), 10, 1'b0);
    check_idle("backpressure");
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush0 = 1'b1; hs0.in_valid = 1'b1; din0 = 999;
    #1;
    checks++;
    if (hs0.in_ready !== 1'b0 || wr_en0 !== 1'b0) begin
      errors++;
      $display("FAIL flush_prio: in_ready=%b wr_en=%b, want 0 0", hs0.in_ready, wr_en0);
    end
    for (int i = 0; i < T0; i++) begin
      @(negedge clk);
      flush0 = 1'b0; hs0.in_valid = 1'b0;
      #1;
      checks++;
      if (wr_en0 !== 1'b1 || zero0 !== 1'b1 || wr_addr0 !== 2'(i)) begin
        errors++;
        $display("FAIL flush cyc %0d: wr_en=%b zero=%b wr_addr=%0d, want 1 1 %0d", i, wr_en0, zero0, wr_addr0, i);
      end
    end
    clear_model();
    run_sample(int'($urandom_range(0, 255)), 0, 1'b0);
  endtask

  task automatic test_reset_mid_mac();
    @(negedge clk);
    hs0.in_valid = 1'b1; flush0 = 1'b0; hs0.out_ready = 1'b1; din0 = 77;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      hs0.in_valid = 1'b0;
    end
    #1;
    checks++;
    if (mac_en0 !== 1'b1 || coeff0 !== 2'd2) begin
      errors++;
      $display("FAIL midmac tap2: mac_en=%b coeff=%0d, want 1 2", mac_en0, coeff0);
    end
    srst0 = 1'b1;
    @(negedge clk);
    srst0 = 1'b0;
    #1;
    check_reset_flush("midmac");
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) check_idle("random_gap");
      if ($urandom_range(0, 5) == 0) test_flush();
      else run_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b1);
    end
    check_idle("random_end");
  endtask

  task automatic test_lat0();
    int ptr;
    @(negedge clk);
    srst1 = 1'b0;
    for (int i = 0; i < T1; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (wr_en1 !== 1'b1 || zero1 !== 1'b1 || wr_addr1 !== 3'(i) || busy1 !== 1'b1) begin
        errors++;
        $display("FAIL lat0 flush %0d: wr_en=%b zero=%b wr_addr=%0d busy=%b, want 1 1 %0d 1",
                 i, wr_en1, zero1, wr_addr1, busy1, i);
      end
    end
    ptr = 0;
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      hs1.in_valid = 1'b1; hs1.out_ready = 1'b1;
      #1;
      checks++;
      if (hs1.in_ready !== 1'b1 || wr_en1 !== 1'b1 || wr_addr1 !== 3'(ptr)) begin
        errors++;
        $display("FAIL lat0 accept %0d: in_ready=%b wr_en=%b wr_addr=%0d, want 1 1 %0d",
                 s, hs1.in_ready, wr_en1, wr_addr1, ptr);
      end
      for (int c = 1; c <= T1 + 1; c++) begin
        @(negedge clk);
        hs1.in_valid = 1'b0;
        #1;
        checks++;
        if (c <= T1) begin
          if (mac_en1 !== 1'b1 || coeff1 !== 3'(c - 1) || rd1 !== 3'((ptr - (c - 1) + T1) % T1) ||
              mac_clr1 !== (c == 1) || hs1.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat0 mac %0d.%0d: mac_en=%b coeff=%0d rd=%0d clr=%b out_valid=%b, want 1 %0d %0d %b 0",
                     s, c, mac_en1, coeff1, rd1, mac_clr1, hs1.out_valid, c - 1, (ptr - (c - 1) + T1) % T1, c == 1);
          end
        end else if (hs1.out_valid !== 1'b1 || mac_en1 !== 1'b0) begin
          errors++;
          $display("FAIL lat0 out %0d: out_valid=%b mac_en=%b, want 1 0", s, hs1.out_valid, mac_en1);
        end
      end
      ptr = (ptr + 1) % T1;
    end
  endtask

  initial begin
    srst0 = 1'b1; flush0 = 1'b0; hs0.in_valid = 1'b0; hs0.out_ready = 1'b0;
    srst1 = 1'b1; flush1 = 1'b0; hs1.in_valid = 1'b0; hs1.out_ready = 1'b0;
    clear_model();
    for (int k = 0; k < T0; k++) ram0[k] = 0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_mac();
    test_random();
    test_lat0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
